// File: rtl/irq_share_arbiter.sv
// -----------------------------------------------------------------------------
// irq_share_arbiter
// Shares a single interrupt-handler FSM among NREQ requesters. A round-robin
// pick selects one requester, forwards its request and continuation flag to
// the handler's EQL/CONT_EQL inputs, then waits for the handler acknowledge,
// for the requester to withdraw, or for a timeout before releasing.
//
// Build option:
//   FIXED_PRIORITY_EN  - when defined, the lowest-index request always wins
//                        and the rotation pointer stays at 0.
//
// Ports:
//   clock        in   rising-edge clock
//   nRESET_G     in   asynchronous active-low reset
//   req          in   [NREQ]  level requests, bit i = requester i
//   cont_req     in   [NREQ]  per-requester continuation flag (-> CONT_EQL)
//   handler_ack  in   handler acknowledge (ACKOUT_REG)
//   clr_err      in   clears sticky timeout_err
//   grant        out  [NREQ]  one-hot grant
//   grant_id     out  [PTR_W] index of current/last winner
//   eql_o        out  handler EQL
//   cont_eql_o   out  handler CONT_EQL
//   busy         out  high in GRANT/WAIT/RELEASE
//   done         out  1-cycle pulse on RELEASE after an acknowledged service
//   timeout_err  out  sticky timeout flag
//
// State  | meaning
// IDLE   | no service; scan requests starting at the rotation pointer
// GRANT  | winner granted, EQL asserted, timer cleared (1 cycle)
// WAIT   | follow winner's request; end on ack, withdrawal or timeout
// RELEASE| grant and EQL dropped, pointer advanced past winner (1 cycle)
// -----------------------------------------------------------------------------
module irq_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 15,
  localparam int PTR_W   = $clog2(NREQ)
) (
  input  logic             clock,
  input  logic             nRESET_G,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  cont_req,
  input  logic             handler_ack,
  input  logic             clr_err,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_id,
  output logic             eql_o,
  output logic             cont_eql_o,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_winner;
  logic [7:0]       r_timer;
  logic [NREQ-1:0]  r_grant;
  logic [PTR_W-1:0] r_grant_id;
  logic             r_eql;
  logic             r_cont_eql;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout_err;

  logic             w_found;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W:0]   w_idx;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_timeout;

  // Scan req starting at r_ptr, wrapping modulo NREQ; first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NREQ))
        w_idx = w_idx - (PTR_W+1)'(NREQ);
      if (!w_found && req[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PTR_W-1:0];
      end
    end
  end

`ifdef FIXED_PRIORITY_EN
  // Pointer pinned at 0 so the scan degenerates to lowest-index-first.
  assign w_ptr_next = '0;
`else
  assign w_ptr_next = (r_winner == PTR_W'(NREQ-1)) ? '0 : r_winner + PTR_W'(1);
`endif

  // Timeout only fires when neither ack nor withdrawal claims the edge.
  assign w_timeout = (r_state == S_WAIT) && !handler_ack && req[r_winner] &&
                     (r_timer == 8'(HOLD_MAX-1));

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_winner      <= '0;
      r_timer       <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_eql         <= 1'b0;
      r_cont_eql    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Set has priority over clear.
      r_timeout_err <= w_timeout | (r_timeout_err & ~clr_err);

      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            r_winner   <= w_pick;
            r_grant    <= NREQ'(1) << w_pick;
            r_grant_id <= w_pick;
            r_eql      <= 1'b1;
            r_cont_eql <= cont_req[w_pick];
            r_busy     <= 1'b1;
            r_timer    <= '0;
          end
        end

        S_GRANT: begin
          r_state    <= S_WAIT;
          r_timer    <= '0;
          r_eql      <= req[r_winner];
          r_cont_eql <= cont_req[r_winner];
        end

        S_WAIT: begin
          if (handler_ack || !req[r_winner] || (r_timer == 8'(HOLD_MAX-1))) begin
            r_state    <= S_RELEASE;
            r_grant    <= '0;
            r_eql      <= 1'b0;
            r_cont_eql <= 1'b0;
            r_done     <= handler_ack;
          end else begin
            r_timer    <= r_timer + 8'd1;
            r_eql      <= req[r_winner];
            r_cont_eql <= cont_req[r_winner];
          end
        end

        S_RELEASE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign eql_o       = r_eql;
  assign cont_eql_o  = r_cont_eql;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_irq_share_arbiter.sv
module tb_irq_share_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 15;
  localparam int PTR_W    = 2;

  logic             clock;
  logic             nRESET_G;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  cont_req;
  logic             handler_ack;
  logic             clr_err;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] grant_id;
  logic             eql_o;
  logic             cont_eql_o;
  logic             busy;
  logic             done;
  logic             timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NREQ-1:0] sb_q[$];

  irq_share_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clock       (clock),
    .nRESET_G    (nRESET_G),
    .req         (req),
    .cont_req    (cont_req),
    .handler_ack (handler_ack),
    .clr_err     (clr_err),
    .grant       (grant),
    .grant_id    (grant_id),
    .eql_o       (eql_o),
    .cont_eql_o  (cont_eql_o),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_grant(input string tag);
    logic [NREQ-1:0] e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(tag, 32'(grant), 32'(e));
    end
  endtask

  initial begin
    int n_wait;
    int last_c;
    int n_gr;
    logic [NREQ-1:0] prev_g;

    nRESET_G = 1'b0; req = '0; cont_req = '0; handler_ack = 1'b0; clr_err = 1'b0;
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    tick();
    nRESET_G = 1'b1;

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_eql", 32'(eql_o), 32'd0);
      check("idle_gid", 32'(grant_id), 32'd0);
    end

    // single service of requester 2
    req = 4'b0100; cont_req = 4'b0100; sb_q.push_back(4'b0100);
    tick();
    pop_grant("single_grant");
    check("single_gid", 32'(grant_id), 32'd2);
    check("single_eql_g", 32'(eql_o), 32'd1);
    check("single_cont_g", 32'(cont_eql_o), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_eql_w", 32'(eql_o), 32'd1);
    check("single_cont_w", 32'(cont_eql_o), 32'd1);
    check("single_grant_w", 32'(grant), 32'b0100);
    tick();
    handler_ack = 1'b1;
    tick();
    check("single_done", 32'(done), 32'd1);
    check("single_rel_grant", 32'(grant), 32'd0);
    check("single_rel_eql", 32'(eql_o), 32'd0);
    check("single_rel_busy", 32'(busy), 32'd1);
    handler_ack = 1'b0; req = '0; cont_req = '0;
    tick();
    check("single_done_once", 32'(done), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_gid_hold", 32'(grant_id), 32'd2);

    // round robin, starting from pointer 3 left by the previous service
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < 5; i++) sb_q.push_back(4'b0001);
`else
    sb_q.push_back(4'b1000); sb_q.push_back(4'b0001); sb_q.push_back(4'b0010);
    sb_q.push_back(4'b0100); sb_q.push_back(4'b1000);
`endif
    req = 4'b1111; handler_ack = 1'b1;
    prev_g = grant; last_c = 0; n_gr = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (grant != '0 && prev_g == '0) begin
        pop_grant("rr_grant");
        if (n_gr > 0) check("rr_spacing", 32'(c - last_c), 32'd4);
        last_c = c;
        n_gr++;
      end
      prev_g = grant;
    end
    check("rr_count", 32'(n_gr), 32'd5);
    req = '0; handler_ack = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick();
    check("rr_drain_busy", 32'(busy), 32'd0);

    // timeout on requester 0
    req = 4'b0001; sb_q.push_back(4'b0001);
    tick();
    pop_grant("to_grant");
    tick();
    n_wait = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant == '0) break;
      n_wait++;
    end
    check("to_wait_cycles", 32'(n_wait), 32'(HOLD_MAX));
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_no_done", 32'(done), 32'd0);
    req = '0;
    tick(); tick(); tick();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_err_clr", 32'(timeout_err), 32'd0);

    // timeout coincident with clr_err: set wins
    req = 4'b0001; sb_q.push_back(4'b0001);
    tick();
    pop_grant("to2_grant");
    repeat (HOLD_MAX) tick();
    check("to2_still_wait", 32'(grant), 32'b0001);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to2_released", 32'(grant), 32'd0);
    check("to2_set_wins", 32'(timeout_err), 32'd1);
    req = '0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to2_clr", 32'(timeout_err), 32'd0);

    // abort: requester 1 withdraws two cycles into WAIT
    req = 4'b0010; cont_req = 4'b0000; sb_q.push_back(4'b0010);
    tick();
    pop_grant("ab_grant");
    check("ab_cont", 32'(cont_eql_o), 32'd0);
    tick(); tick();
    check("ab_eql_wait", 32'(eql_o), 32'd1);
    req = '0;
    tick();
    check("ab_eql_fall", 32'(eql_o), 32'd0);
    check("ab_grant_rel", 32'(grant), 32'd0);
    check("ab_no_done", 32'(done), 32'd0);
    check("ab_no_terr", 32'(timeout_err), 32'd0);
    tick();

    // pointer now 2 (round robin) / 0 (fixed)
    req = 4'b0101;
`ifdef FIXED_PRIORITY_EN
    sb_q.push_back(4'b0001);
`else
    sb_q.push_back(4'b0100);
`endif
    tick();
    pop_grant("ptr_grant");
    tick();
    check("ar_in_wait", 32'(busy), 32'd1);

    // async reset between edges
    #2;
    nRESET_G = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_eql", 32'(eql_o), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_gid", 32'(grant_id), 32'd0);
    nRESET_G = 1'b1;
    req = 4'b1010; sb_q.push_back(4'b0010);
    tick();
    pop_grant("ar_regrant");
    check("ar_regrant_gid", 32'(grant_id), 32'd1);
    req = '0;
    for (int i = 0; i < 10 && busy; i++) tick();
    check("end_busy", 32'(busy), 32'd0);
    check("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
